// File: rtl/turn_signal_seq.sv
// Turn-signal sequencer: N lamps per side with left/right fill sweep, hazard flash,
// brake override and restart on every mode change. All outputs are registered.
module turn_signal_seq #(
    parameter int unsigned N_LIGHTS = 3,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                left_req,
    input  logic                right_req,
    input  logic                hazard_req,
    input  logic                brake,
    output logic [N_LIGHTS-1:0] lights_left,
    output logic [N_LIGHTS-1:0] lights_right,
    output logic [1:0]          state_o
);

    localparam int unsigned KW = $clog2(N_LIGHTS + 1);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    mode_t               state;
    mode_t               state_nxt;
    mode_t               req_mode;
    logic [KW-1:0]       k;
    logic [KW-1:0]       k_nxt;
    logic [TW-1:0]       tcnt;
    logic [TW-1:0]       tcnt_nxt;
    logic                hp;
    logic                hp_nxt;
    logic                tick;
    logic [N_LIGHTS-1:0] fill_left;
    logic [N_LIGHTS-1:0] fill_right;
    logic [N_LIGHTS-1:0] brake_bank;
    logic [N_LIGHTS-1:0] left_nxt;
    logic [N_LIGHTS-1:0] right_nxt;

    // State register; outputs are registered from the next-state values so a
    // request sampled at an edge shows its first pattern right after that edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            k            <= '0;
            tcnt         <= '0;
            hp           <= 1'b0;
            lights_left  <= '0;
            lights_right <= '0;
            state_o      <= 2'd0;
        end else begin
            state        <= state_nxt;
            k            <= k_nxt;
            tcnt         <= tcnt_nxt;
            hp           <= hp_nxt;
            lights_left  <= left_nxt;
            lights_right <= right_nxt;
            state_o      <= 2'(state_nxt);
        end
    end

    // Request decode and next-state / sequence counters
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        tcnt_nxt  = tcnt;
        hp_nxt    = hp;
        req_mode  = IDLE;
        tick      = (tcnt == TW'(TICK_DIV - 1));

        if (hazard_req || (left_req && right_req)) begin
            req_mode = HAZARD;
        end else if (left_req) begin
            req_mode = LEFT;
        end else if (right_req) begin
            req_mode = RIGHT;
        end

        if (!enable) begin
            state_nxt = IDLE;
            k_nxt     = '0;
            tcnt_nxt  = '0;
            hp_nxt    = 1'b0;
        end else if (req_mode != state) begin
            state_nxt = req_mode;
            k_nxt     = KW'(1);
            tcnt_nxt  = '0;
            hp_nxt    = 1'b1;
        end else if (state == IDLE) begin
            tcnt_nxt = '0;
        end else begin
            tcnt_nxt = tick ? '0 : tcnt + TW'(1);
            if (tick) begin
                if (state == HAZARD) begin
                    hp_nxt = ~hp;
                end else begin
                    k_nxt = (k == KW'(N_LIGHTS)) ? '0 : k + KW'(1);
                end
            end
        end
    end

    // Lamp patterns for the next state
    always_comb begin
        fill_left  = '0;
        fill_right = '0;
        left_nxt   = '0;
        right_nxt  = '0;
        brake_bank = brake ? '1 : '0;

        for (int i = 0; i < int'(N_LIGHTS); i++) begin
            fill_left[i]  = (i < int'(k_nxt));
            fill_right[i] = (i >= int'(N_LIGHTS) - int'(k_nxt));
        end

        if (enable) begin
            case (state_nxt)
                LEFT: begin
                    left_nxt  = fill_left;
                    right_nxt = brake_bank;
                end
                RIGHT: begin
                    left_nxt  = brake_bank;
                    right_nxt = fill_right;
                end
                HAZARD: begin
                    left_nxt  = {N_LIGHTS{hp_nxt}};
                    right_nxt = {N_LIGHTS{hp_nxt}};
                end
                default: begin
                    left_nxt  = brake_bank;
                    right_nxt = brake_bank;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq: directed vector table on a 3-lamp/4-cycle instance,
// plus an age-based reference model checking a 5-lamp/1-cycle instance and random traffic.
module tb_turn_signal_seq;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable, left_req, right_req, hazard_req, brake;
    logic [2:0] l3, r3;
    logic [4:0] l5, r5;
    logic [1:0] s3, s5;

    int checks = 0;
    int errors = 0;

    // Reference model: current mode and cycles spent in it since the last load
    int m_mode = 0;
    int m_age  = 0;
    bit m_brk  = 1'b0;
    bit m_en   = 1'b0;

    always #5 clock = ~clock;

    turn_signal_seq #(.N_LIGHTS(3), .TICK_DIV(4)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .left_req(left_req),
        .right_req(right_req), .hazard_req(hazard_req), .brake(brake),
        .lights_left(l3), .lights_right(r3), .state_o(s3)
    );

    turn_signal_seq #(.N_LIGHTS(5), .TICK_DIV(1)) dut5 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .left_req(left_req),
        .right_req(right_req), .hazard_req(hazard_req), .brake(brake),
        .lights_left(l5), .lights_right(r5), .state_o(s5)
    );

    typedef struct {
        logic       en, lr, rr, hr, br;
        int         hold;
        logic [2:0] el, er;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected lamps from mode and age: step index and hazard phase follow from age/td
    function automatic void exp_lamps(input int n, input int td,
                                      output logic [7:0] el, output logic [7:0] er);
        int ones, k, bk;
        ones = (1 << n) - 1;
        k    = (1 + m_age / td) % (n + 1);
        bk   = m_brk ? ones : 0;
        el   = 8'(bk);
        er   = 8'(bk);
        if (!m_en) begin
            el = 8'd0;
            er = 8'd0;
        end else if (m_mode == 1) begin
            el = 8'((1 << k) - 1);
        end else if (m_mode == 2) begin
            er = 8'(ones & ~((1 << (n - k)) - 1));
        end else if (m_mode == 3) begin
            el = ((m_age / td) % 2 == 0) ? 8'(ones) : 8'd0;
            er = el;
        end
    endfunction

    task automatic step(input bit cmp3);
        int         rq;
        logic [7:0] el, er;
        @(posedge clock);
        if (!enable) begin
            m_mode = 0;
            m_age  = 0;
        end else begin
            rq = (hazard_req || (left_req && right_req)) ? 3 : left_req ? 1 : right_req ? 2 : 0;
            if (rq != m_mode) begin
                m_mode = rq;
                m_age  = 0;
            end else begin
                m_age++;
            end
        end
        m_brk = brake;
        m_en  = enable;
        #1;
        exp_lamps(5, 1, el, er);
        chk("n5_left", 8'(l5), el);
        chk("n5_right", 8'(r5), er);
        chk("n5_state", 8'(s5), 8'(m_mode));
        if (cmp3) begin
            exp_lamps(3, 4, el, er);
            chk("n3_left", 8'(l3), el);
            chk("n3_right", 8'(r3), er);
            chk("n3_state", 8'(s3), 8'(m_mode));
        end
    endtask

    task automatic drive(input logic en, input logic lr, input logic rr,
                         input logic hr, input logic br);
        enable     = en;
        left_req   = lr;
        right_req  = rr;
        hazard_req = hr;
        brake      = br;
    endtask

    logic [4:0] exp5 [6];

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp5 = '{5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000, 5'b00001};

        // en lr rr hr br hold  left   right  state
        vecs.push_back('{1, 1, 0, 0, 0, 1, 3'b001, 3'b000, 2'd1});
        vecs.push_back('{1, 1, 0, 0, 0, 3, 3'b001, 3'b000, 2'd1});
        vecs.push_back('{1, 1, 0, 0, 0, 1, 3'b011, 3'b000, 2'd1});
        vecs.push_back('{1, 1, 0, 0, 0, 4, 3'b111, 3'b000, 2'd1});
        vecs.push_back('{1, 1, 0, 0, 0, 4, 3'b000, 3'b000, 2'd1});
        vecs.push_back('{1, 1, 0, 0, 0, 4, 3'b001, 3'b000, 2'd1});
        vecs.push_back('{1, 0, 0, 0, 0, 1, 3'b000, 3'b000, 2'd0});
        vecs.push_back('{1, 0, 0, 0, 1, 1, 3'b111, 3'b111, 2'd0});
        vecs.push_back('{1, 0, 1, 0, 0, 1, 3'b000, 3'b100, 2'd2});
        vecs.push_back('{1, 0, 1, 0, 0, 4, 3'b000, 3'b110, 2'd2});
        vecs.push_back('{1, 0, 1, 0, 0, 4, 3'b000, 3'b111, 2'd2});
        vecs.push_back('{1, 0, 1, 0, 0, 4, 3'b000, 3'b000, 2'd2});
        vecs.push_back('{1, 1, 1, 0, 0, 1, 3'b111, 3'b111, 2'd3});
        vecs.push_back('{1, 1, 1, 0, 1, 3, 3'b111, 3'b111, 2'd3});
        vecs.push_back('{1, 1, 1, 0, 1, 1, 3'b000, 3'b000, 2'd3});
        vecs.push_back('{1, 1, 1, 0, 0, 4, 3'b111, 3'b111, 2'd3});
        vecs.push_back('{1, 0, 0, 1, 0, 1, 3'b111, 3'b111, 2'd3});
        vecs.push_back('{1, 1, 0, 0, 0, 5, 3'b011, 3'b000, 2'd1});
        vecs.push_back('{1, 1, 0, 0, 1, 1, 3'b011, 3'b111, 2'd1});
        vecs.push_back('{1, 1, 0, 0, 1, 3, 3'b111, 3'b111, 2'd1});
        vecs.push_back('{1, 0, 1, 0, 0, 1, 3'b000, 3'b100, 2'd2});
        vecs.push_back('{1, 0, 1, 0, 0, 3, 3'b000, 3'b100, 2'd2});
        vecs.push_back('{1, 0, 1, 0, 0, 1, 3'b000, 3'b110, 2'd2});
        vecs.push_back('{0, 0, 1, 0, 0, 1, 3'b000, 3'b000, 2'd0});
        vecs.push_back('{0, 0, 1, 0, 1, 1, 3'b000, 3'b000, 2'd0});
        vecs.push_back('{1, 0, 1, 0, 0, 1, 3'b000, 3'b100, 2'd2});

        repeat (2) @(posedge clock);
        #1;
        chk("reset_l3", 8'(l3), 8'd0);
        chk("reset_r3", 8'(r3), 8'd0);
        chk("reset_s3", 8'(s3), 8'd0);
        chk("reset_l5", 8'(l5), 8'd0);
        chk("reset_s5", 8'(s5), 8'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].lr, vecs[i].rr, vecs[i].hr, vecs[i].br);
            for (int c = 0; c < vecs[i].hold; c++) step(1'b0);
            chk($sformatf("vec%0d_left", i), 8'(l3), 8'(vecs[i].el));
            chk($sformatf("vec%0d_right", i), 8'(r3), 8'(vecs[i].er));
            chk($sformatf("vec%0d_state", i), 8'(s3), 8'(vecs[i].es));
        end

        // Asynchronous reset mid-sequence, then restart on first edge
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_l3", 8'(l3), 8'd0);
        chk("async_rst_r3", 8'(r3), 8'd0);
        chk("async_rst_s3", 8'(s3), 8'd0);
        chk("async_rst_l5", 8'(l5), 8'd0);
        m_mode = 0;
        m_age  = 0;
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1);
        chk("post_rst_l3", 8'(l3), 8'b001);
        chk("post_rst_s3", 8'(s3), 8'd1);
        chk("post_rst_l5", 8'(l5), 8'b00001);

        // Five-lamp single-cycle sweep
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            chk($sformatf("n5_sweep%0d", i), 8'(l5), 8'(exp5[i]));
        end

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) begin
                left_req   = 1'($urandom_range(1));
                right_req  = 1'($urandom_range(1));
                hazard_req = ($urandom_range(3) == 0);
            end
            if ($urandom_range(5) == 0) brake = ~brake;
            enable = ($urandom_range(15) != 0);
            step(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/turn_signal_seq.md
# turn_signal_seq

Parametrised turn-signal sequencer driving two banks of N lamps (left, right) for the lab tail-light controller. It replaces the fixed 3-lamp sequencer with the following:
- configurable lamp count and step rate
- hazard mode
- brake override
- clean restart on any mode change

It sits between the debounced switch/request logic and the LED drivers. All outputs are registered.

## Interface
- N_LIGHTS, 3, lamps per side; legal range ≥ 2.
- TICK_DIV, 4, clock cycles per sequence step; legal range ≥ 1 (1 = step every cycle).
- clock  in  1  rising-edge system clock.
- reset_n  in  1  reset, asynchronous, active-low; clock clock.
- enable  in  1  synchronous run enable; 0 forces IDLE with all lamps off.
- left_req  in  1  level request, left turn.
- right_req  in  1  level request, right turn.
- hazard_req  in  1  level request, hazard flash.
- brake  in  1  level, brake pedal.
- lights_left  out  N_LIGHTS  left bank; bit 0 is the innermost lamp.
- lights_right  out  N_LIGHTS  right bank; bit N_LIGHTS-1 is the innermost lamp.
- state_o  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.

## Operation
- Requested mode is decoded every cycle:
  - hazard_req=1, or left_req=right_req=1 → HAZARD
  - else left_req → LEFT
  - else right_req → RIGHT
  - else IDLE
- Mode change:
  - If the requested mode differs from the current mode, the state is loaded with the requested mode at the next edge.
  - On that load, step index k=1, tick counter tcnt=0 and hazard phase hp=1.
  - A direct LEFT→RIGHT switch restarts the sequence; there is no pass through IDLE.
- Tick counter:
  - tcnt counts 0..TICK_DIV-1 in non-IDLE states.
  - tick = (tcnt==TICK_DIV-1); tcnt wraps to 0 on tick.
  - tcnt is held at 0 in IDLE.
- LEFT/RIGHT stepping:
  - k ranges 0..N_LIGHTS (width $clog2(N_LIGHTS+1)).
  - On tick: k = (k==N_LIGHTS) ? 0 : k+1.
  - The pattern fills inward to outward, then all lamps go off for one step.
- LEFT outputs: lights_left bits [k-1:0] = 1, others 0; lights_right = brake ? all ones : 0.
- RIGHT outputs (mirror of LEFT): lights_right bits [N-1:N-k] = 1, others 0; lights_left = brake ? all ones : 0.
- HAZARD:
  - hp toggles on tick.
  - Both banks are all ones when hp=1, all zeros when hp=0.
  - brake is ignored.
- IDLE: both banks = brake ? all ones : 0.
- enable=0: next edge forces IDLE, k=0, tcnt=0, hp=0 and all lamps off (brake also ignored). Requests are ignored until enable returns to 1.
- reset_n=0: immediately forces IDLE, k=0, tcnt=0, hp=0, lights_left=0, lights_right=0, state_o=0. This applies from any state, including mid-sequence.

## Timing
- Reset values: every output and internal register is 0.
- Latency:
  - A request sampled at edge t produces state_o and the first pattern (k=1 or hp=1) at the outputs right after edge t.
  - Brake changes appear one edge later.
- Step period: TICK_DIV cycles. The full LEFT/RIGHT cycle is (N_LIGHTS+1)*TICK_DIV cycles; the full hazard cycle is 2*TICK_DIV cycles.
- Request deassert: at the next edge the block goes to IDLE and turn lamps go off the same cycle (brake lamps if brake=1). Sequence position is not retained.
- A request glitch shorter than one cycle that is not sampled has no effect.
- First reset_n rising edge: the block stays in IDLE until requests are sampled at the next clock edge.

## Test plan
- Left sweep, N=3, TICK_DIV=4: left_req=1 from edge 0 → lights_left 001 at edge 0, 011 at edge 4, 111 at edge 8, 000 at edge 12, 001 at edge 16; lights_right stays 000; state_o=1.
- Right sweep, same parameters: lights_right 100 → 110 → 111 → 000 on 4-cycle steps; lights_left stays 000.
- Hazard by left_req & right_req: both banks 111 for 4 cycles, then 000 for 4 cycles, repeating; state_o=3; asserting brake changes nothing.
- Brake during LEFT at k=2: lights_right becomes 111 one edge after brake rises while lights_left continues 011 → 111; in IDLE with brake=1 both banks are 111.
- Mode switch: LEFT at k=3 (111), then right_req=1 and left_req=0 on the same edge → lights_right=100, lights_left=000, tcnt restarts at 0.
- Reset and enable: reset_n pulsed low mid-sequence → all outputs 0 asynchronously, then k=1 on the first edge after release if left_req is held; enable=0 for 1 cycle → lamps 000 and state_o=0 at the next edge.
- Parameter sweep: N_LIGHTS=5, TICK_DIV=1 → left pattern steps every cycle, period 6 cycles, final pattern 11111 → 00000.
